// File: rtl/riscv_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// riscv_hazard_ctrl_if
// Bundle between the 5-stage pipeline and its hazard/flow controller.
//   Pipeline -> controller : ID source registers and opcode, EX/MEM/WB
//                            destination registers and writeback enables,
//                            EX load flag, EX taken-branch flag, MEM request,
//                            data-memory ready.
//   Controller -> pipeline : per-register stall and flush enables, sticky
//                            memory timeout flag, stall/flush event counters.
// Modports:
//   master - pipeline side (drives status, receives controls)
//   slave  - hazard controller side
// ---------------------------------------------------------------------------
interface riscv_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] ID_rs1_i;
    logic [REG_AW-1:0] ID_rs2_i;
    logic [6:0]        ID_opcode_i;
    logic [REG_AW-1:0] EX_rd_i;
    logic [REG_AW-1:0] MEM_rd_i;
    logic [REG_AW-1:0] WB_rd_i;
    logic              EX_RegWr_en;
    logic              MEM_RegWr_en;
    logic              WB_RegWr_en;
    logic              EX_MemRd_en;
    logic              EX_Br_taken_i;
    logic              MEM_Req_i;
    logic              DMEM_ready_i;

    logic              PC_stall_o;
    logic              IFID_stall_o;
    logic              IDEX_stall_o;
    logic              EXMEM_stall_o;
    logic              WB_stall_o;
    logic              IFID_flush_o;
    logic              IDEX_flush_o;
    logic              EXMEM_flush_o;
    logic              WB_flush_o;
    logic              mem_timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output ID_rs1_i, ID_rs2_i, ID_opcode_i,
        output EX_rd_i, MEM_rd_i, WB_rd_i,
        output EX_RegWr_en, MEM_RegWr_en, WB_RegWr_en,
        output EX_MemRd_en, EX_Br_taken_i, MEM_Req_i, DMEM_ready_i,
        input  PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o, WB_stall_o,
        input  IFID_flush_o, IDEX_flush_o, EXMEM_flush_o, WB_flush_o,
        input  mem_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ID_rs1_i, ID_rs2_i, ID_opcode_i,
        input  EX_rd_i, MEM_rd_i, WB_rd_i,
        input  EX_RegWr_en, MEM_RegWr_en, WB_RegWr_en,
        input  EX_MemRd_en, EX_Br_taken_i, MEM_Req_i, DMEM_ready_i,
        output PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o, WB_stall_o,
        output IFID_flush_o, IDEX_flush_o, EXMEM_flush_o, WB_flush_o,
        output mem_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_hazard_ctrl
// Hazard and flow controller for the 5-stage RISC-V pipeline. It is the only
// source of the stall/flush enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Priority, highest first: data-memory wait, taken-branch flush, RAW hazard.
// Ports:
//   clk_i    - clock, rising edge
//   rst_n_i  - asynchronous active-low reset; while low all stalls are 0
//              and all flushes are 1
//   hz       - riscv_hazard_ctrl_if.slave: pipeline status in, controls,
//              sticky timeout flag and saturating event counters out
// Stall/flush outputs are combinational from inputs plus registered state;
// the FSM, counters and timeout flag update on the rising clock edge.
// ---------------------------------------------------------------------------
module riscv_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int FWD_EN    = 1,
    parameter int WB_HAZ    = 1,
    parameter int FLUSH_CYC = 1,
    parameter int MEM_TMO   = 15,
    parameter int CNT_W     = 16
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    riscv_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int              WCW         = $clog2(MEM_TMO + 1);
    localparam logic [WCW-1:0]  TMO_V       = WCW'(MEM_TMO);
    localparam logic [WCW-1:0]  WCNT_ONE    = WCW'(32'd1);
    localparam logic [2:0]      FLUSH_LOAD  = 3'(FLUSH_CYC - 1);
    localparam bit              MULTI_FLUSH = (FLUSH_CYC > 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    // Decode helpers: which ID sources are real operands.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_JAL) || (op == OP_LUI) || (op == OP_AUIPC));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_BR) || (op == OP_ST);
    endfunction

    // A used, non-x0 source that matches a writing producer.
    function automatic logic src_hit(input logic              used,
                                     input logic [REG_AW-1:0] src,
                                     input logic              wr_en,
                                     input logic [REG_AW-1:0] rd);
        return used && (src != {REG_AW{1'b0}}) && wr_en && (src == rd);
    endfunction

    state_t           state_r;
    state_t           saved_r;
    logic [2:0]       flush_left_r;
    logic [WCW-1:0]   wait_cnt_r;
    logic             timeout_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic rs1_used_s, rs2_used_s;
    logic ex_hit_s, mem_hit_s, wb_hit_s;
    logic raw_s;
    logic mem_wait_s;
    logic flush_phase_s;
    logic branch_s;
    logic pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s;
    logic ifid_flush_s, idex_flush_s, exmem_flush_s, wb_flush_s;

    // Operand use and producer matching for the ID instruction.
    always_comb begin
        rs1_used_s = uses_rs1(hz.ID_opcode_i);
        rs2_used_s = uses_rs2(hz.ID_opcode_i);
        ex_hit_s   = src_hit(rs1_used_s, hz.ID_rs1_i, hz.EX_RegWr_en, hz.EX_rd_i)
                   | src_hit(rs2_used_s, hz.ID_rs2_i, hz.EX_RegWr_en, hz.EX_rd_i);
        mem_hit_s  = src_hit(rs1_used_s, hz.ID_rs1_i, hz.MEM_RegWr_en, hz.MEM_rd_i)
                   | src_hit(rs2_used_s, hz.ID_rs2_i, hz.MEM_RegWr_en, hz.MEM_rd_i);
        wb_hit_s   = src_hit(rs1_used_s, hz.ID_rs1_i, hz.WB_RegWr_en, hz.WB_rd_i)
                   | src_hit(rs2_used_s, hz.ID_rs2_i, hz.WB_RegWr_en, hz.WB_rd_i);
    end

    // RAW hazard: with forwarding only a load in EX can't be bypassed in time.
    always_comb begin
        if (FWD_EN != 0) begin
            raw_s = hz.EX_MemRd_en & ex_hit_s;
        end else if (WB_HAZ != 0) begin
            raw_s = ex_hit_s | mem_hit_s | wb_hit_s;
        end else begin
            raw_s = ex_hit_s | mem_hit_s;
        end
    end

    // Flush phase also covers the ready cycle of a wait that interrupted a
    // flush, so the remaining bubbles follow the wait without a gap.
    always_comb begin
        mem_wait_s    = hz.MEM_Req_i & ~hz.DMEM_ready_i;
        flush_phase_s = (state_r == ST_FLUSH) ||
                        ((state_r == ST_WAIT) && (saved_r == ST_FLUSH));
        branch_s      = hz.EX_Br_taken_i | flush_phase_s;
    end

    // Prioritised stall/flush selection.
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        idex_stall_s  = 1'b0;
        exmem_stall_s = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        wb_flush_s    = 1'b0;
        if (mem_wait_s) begin
            // Freeze everything up to EX/MEM; WB gets a bubble so the waiting
            // access does not write back twice.
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_stall_s  = 1'b1;
            exmem_stall_s = 1'b1;
            wb_flush_s    = 1'b1;
        end else if (branch_s) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = hz.EX_Br_taken_i;
        end else if (raw_s) begin
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_flush_s  = 1'b1;
        end else begin
            pc_stall_s    = 1'b0;
            idex_flush_s  = 1'b0;
        end
    end

    // Reset forces the pipeline into a fully flushed, non-stalled state.
    assign hz.PC_stall_o    = rst_n_i & pc_stall_s;
    assign hz.IFID_stall_o  = rst_n_i & ifid_stall_s;
    assign hz.IDEX_stall_o  = rst_n_i & idex_stall_s;
    assign hz.EXMEM_stall_o = rst_n_i & exmem_stall_s;
    assign hz.WB_stall_o    = 1'b0;
    assign hz.IFID_flush_o  = ~rst_n_i | ifid_flush_s;
    assign hz.IDEX_flush_o  = ~rst_n_i | idex_flush_s;
    assign hz.EXMEM_flush_o = ~rst_n_i | exmem_flush_s;
    assign hz.WB_flush_o    = ~rst_n_i | wb_flush_s;
    assign hz.mem_timeout_o = timeout_r;
    assign hz.stall_cnt_o   = stall_cnt_r;
    assign hz.flush_cnt_o   = flush_cnt_r;

    // Flow FSM: RUN / FLUSH / WAIT with flush and wait counters, timeout flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_RUN;
            saved_r      <= ST_RUN;
            flush_left_r <= 3'd0;
            wait_cnt_r   <= {WCW{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_wait_s) begin
                        state_r    <= ST_WAIT;
                        saved_r    <= ST_RUN;
                        wait_cnt_r <= {WCW{1'b0}};
                    end else if (hz.EX_Br_taken_i && MULTI_FLUSH) begin
                        state_r      <= ST_FLUSH;
                        flush_left_r <= FLUSH_LOAD;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (mem_wait_s) begin
                        // Flush counter is frozen for the duration of the wait.
                        state_r    <= ST_WAIT;
                        saved_r    <= ST_FLUSH;
                        wait_cnt_r <= {WCW{1'b0}};
                    end else if (hz.EX_Br_taken_i) begin
                        flush_left_r <= FLUSH_LOAD;
                    end else if (flush_left_r > 3'd1) begin
                        flush_left_r <= flush_left_r - 3'd1;
                    end else begin
                        state_r      <= ST_RUN;
                        flush_left_r <= 3'd0;
                    end
                end
                ST_WAIT: begin
                    if (mem_wait_s) begin
                        if (wait_cnt_r != TMO_V) begin
                            wait_cnt_r <= wait_cnt_r + WCNT_ONE;
                        end else begin
                            wait_cnt_r <= wait_cnt_r;
                        end
                        if (wait_cnt_r == (TMO_V - WCNT_ONE)) begin
                            timeout_r <= 1'b1;
                        end else begin
                            timeout_r <= timeout_r;
                        end
                    end else if (hz.EX_Br_taken_i && MULTI_FLUSH) begin
                        state_r      <= ST_FLUSH;
                        flush_left_r <= FLUSH_LOAD;
                    end else if ((saved_r == ST_FLUSH) && (flush_left_r > 3'd1)) begin
                        // Ready cycle already counted as one flush cycle.
                        state_r      <= ST_FLUSH;
                        flush_left_r <= flush_left_r - 3'd1;
                    end else begin
                        state_r      <= ST_RUN;
                        flush_left_r <= 3'd0;
                    end
                end
                default: begin
                    state_r      <= ST_RUN;
                    flush_left_r <= 3'd0;
                end
            endcase
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pc_stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            // A branch held in EX by a memory wait is counted once, when it
            // actually takes effect.
            if (hz.EX_Br_taken_i && !mem_wait_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_riscv_hazard_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic [6:0] op;
        logic [4:0] ex_rd, mem_rd, wb_rd;
        logic       ex_we, mem_we, wb_we, ex_ld, br, req, rdy;
    } vec_t;

    typedef struct {
        bit          tgt;
        logic [4:0]  stall;
        logic [3:0]  flush;
        logic        tmo;
        bit          chk_tmo;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        string       name;
    } exp_t;

    vec_t cur, nxt;
    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rst_n;

    riscv_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hf ();
    riscv_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hn ();

    assign rst_n = cur.rst;

    assign hf.ID_rs1_i = cur.rs1;       assign hn.ID_rs1_i = cur.rs1;
    assign hf.ID_rs2_i = cur.rs2;       assign hn.ID_rs2_i = cur.rs2;
    assign hf.ID_opcode_i = cur.op;     assign hn.ID_opcode_i = cur.op;
    assign hf.EX_rd_i = cur.ex_rd;      assign hn.EX_rd_i = cur.ex_rd;
    assign hf.MEM_rd_i = cur.mem_rd;    assign hn.MEM_rd_i = cur.mem_rd;
    assign hf.WB_rd_i = cur.wb_rd;      assign hn.WB_rd_i = cur.wb_rd;
    assign hf.EX_RegWr_en = cur.ex_we;  assign hn.EX_RegWr_en = cur.ex_we;
    assign hf.MEM_RegWr_en = cur.mem_we; assign hn.MEM_RegWr_en = cur.mem_we;
    assign hf.WB_RegWr_en = cur.wb_we;  assign hn.WB_RegWr_en = cur.wb_we;
    assign hf.EX_MemRd_en = cur.ex_ld;  assign hn.EX_MemRd_en = cur.ex_ld;
    assign hf.EX_Br_taken_i = cur.br;   assign hn.EX_Br_taken_i = cur.br;
    assign hf.MEM_Req_i = cur.req;      assign hn.MEM_Req_i = cur.req;
    assign hf.DMEM_ready_i = cur.rdy;   assign hn.DMEM_ready_i = cur.rdy;

    riscv_hazard_ctrl #(
        .REG_AW(5), .FWD_EN(1), .WB_HAZ(1), .FLUSH_CYC(3), .MEM_TMO(4), .CNT_W(16)
    ) dut_f (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hf.slave)
    );

    riscv_hazard_ctrl #(
        .REG_AW(5), .FWD_EN(0), .WB_HAZ(1), .FLUSH_CYC(3), .MEM_TMO(4), .CNT_W(16)
    ) dut_n (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hn.slave)
    );

    task automatic idle();
        nxt        = '0;
        nxt.rst    = 1'b1;
        nxt.op     = OP_I;
        nxt.rdy    = 1'b1;
    endtask

    // Apply nxt just after a rising edge and queue the expected response.
    task automatic step(input bit tgt, input logic [4:0] es, input logic [3:0] ef,
                        input logic et, input bit ct, input int sc, input int fc,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        cur       = nxt;
        e.tgt     = tgt;
        e.stall   = es;
        e.flush   = ef;
        e.tmo     = et;
        e.chk_tmo = ct;
        e.scnt    = 16'(sc);
        e.fcnt    = 16'(fc);
        e.name    = nm;
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input bit tgt);
        idle();
        nxt.rst = 1'b0;
        step(tgt, 5'b00000, 4'b1111, 1'b0, 1'b1, 0, 0, "reset");
        idle();
        step(tgt, 5'b00000, 4'b0000, 1'b0, 1'b1, 0, 0, "release");
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin
        exp_t        e;
        logic [4:0]  as;
        logic [3:0]  af;
        logic        at;
        logic [15:0] asc, afc;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.tgt == 1'b0) begin
                    as  = {hf.PC_stall_o, hf.IFID_stall_o, hf.IDEX_stall_o, hf.EXMEM_stall_o, hf.WB_stall_o};
                    af  = {hf.IFID_flush_o, hf.IDEX_flush_o, hf.EXMEM_flush_o, hf.WB_flush_o};
                    at  = hf.mem_timeout_o;
                    asc = hf.stall_cnt_o;
                    afc = hf.flush_cnt_o;
                end else begin
                    as  = {hn.PC_stall_o, hn.IFID_stall_o, hn.IDEX_stall_o, hn.EXMEM_stall_o, hn.WB_stall_o};
                    af  = {hn.IFID_flush_o, hn.IDEX_flush_o, hn.EXMEM_flush_o, hn.WB_flush_o};
                    at  = hn.mem_timeout_o;
                    asc = hn.stall_cnt_o;
                    afc = hn.flush_cnt_o;
                end
                n_chk++;
                if ((as === e.stall) && (af === e.flush) && (!e.chk_tmo || (at === e.tmo)) &&
                    (asc === e.scnt) && (afc === e.fcnt)) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got stall=%b flush=%b tmo=%b scnt=%0d fcnt=%0d, expected stall=%b flush=%b tmo=%b scnt=%0d fcnt=%0d",
                             e.name, as, af, at, asc, afc, e.stall, e.flush, e.tmo, e.scnt, e.fcnt);
                end
            end
        end
    end

    initial begin
        idle();
        nxt.rst = 1'b0;
        cur     = nxt;

        // Reset state of both instances, then release.
        step(1'b0, 5'b00000, 4'b1111, 1'b0, 1'b1, 0, 0, "rst_f");
        step(1'b1, 5'b00000, 4'b1111, 1'b0, 1'b1, 0, 0, "rst_n");
        idle();
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 0, 0, "idle_f");

        // Load-use with forwarding: lw x5 in EX, add x6,x5,x7 in ID.
        idle(); nxt.op = OP_R; nxt.rs1 = 5'd5; nxt.rs2 = 5'd7;
        nxt.ex_rd = 5'd5; nxt.ex_we = 1'b1; nxt.ex_ld = 1'b1;
        step(1'b0, 5'b11000, 4'b0100, 1'b0, 1'b1, 0, 0, "lu_stall");
        nxt.ex_we = 1'b0; nxt.ex_ld = 1'b0; nxt.ex_rd = 5'd0;
        nxt.mem_rd = 5'd5; nxt.mem_we = 1'b1;
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 1, 0, "lu_release");
        idle(); nxt.op = OP_R; nxt.rs1 = 5'd0; nxt.rs2 = 5'd7;
        nxt.ex_rd = 5'd0; nxt.ex_we = 1'b1; nxt.ex_ld = 1'b1;
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 1, 0, "lu_x0");
        nxt.rs1 = 5'd5; nxt.ex_rd = 5'd5; nxt.ex_ld = 1'b0;
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 1, 0, "alu_fwd");

        // Taken branch, FLUSH_CYC=3, with a simultaneous load-use RAW.
        do_reset(1'b0);
        idle(); nxt.br = 1'b1; nxt.op = OP_R; nxt.rs1 = 5'd5;
        nxt.ex_rd = 5'd5; nxt.ex_we = 1'b1; nxt.ex_ld = 1'b1;
        step(1'b0, 5'b00000, 4'b1100, 1'b0, 1'b1, 0, 0, "br_take");
        idle();
        step(1'b0, 5'b00000, 4'b1000, 1'b0, 1'b1, 0, 1, "br_flush1");
        step(1'b0, 5'b00000, 4'b1000, 1'b0, 1'b1, 0, 1, "br_flush2");
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 0, 1, "br_done");

        // Six-cycle memory wait, MEM_TMO=4; timeout not yet allowed in the
        // first four cycles, set by the sixth, sticky after ready.
        do_reset(1'b0);
        idle(); nxt.req = 1'b1; nxt.rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 5'b11110, 4'b0001, (k == 5), (k != 4), k, 0, "mem_wait");
        end
        nxt.rdy = 1'b1;
        step(1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 6, 0, "mw_ready");
        idle();
        step(1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 6, 0, "mw_sticky");

        // Two-cycle wait right after a taken branch.
        do_reset(1'b0);
        idle(); nxt.br = 1'b1;
        step(1'b0, 5'b00000, 4'b1100, 1'b0, 1'b1, 0, 0, "wf_br");
        idle(); nxt.req = 1'b1; nxt.rdy = 1'b0;
        step(1'b0, 5'b11110, 4'b0001, 1'b0, 1'b1, 0, 1, "wf_wait1");
        step(1'b0, 5'b11110, 4'b0001, 1'b0, 1'b1, 1, 1, "wf_wait2");
        idle();
        step(1'b0, 5'b00000, 4'b1000, 1'b0, 1'b1, 2, 1, "wf_resume1");
        step(1'b0, 5'b00000, 4'b1000, 1'b0, 1'b1, 2, 1, "wf_resume2");
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 2, 1, "wf_done");

        // Reset asserted in the second wait cycle.
        idle(); nxt.req = 1'b1; nxt.rdy = 1'b0;
        step(1'b0, 5'b11110, 4'b0001, 1'b0, 1'b1, 2, 1, "rw_wait1");
        nxt.rst = 1'b0;
        step(1'b0, 5'b00000, 4'b1111, 1'b0, 1'b1, 0, 0, "rw_reset");
        step(1'b0, 5'b00000, 4'b1111, 1'b0, 1'b1, 0, 0, "rw_hold");
        idle(); nxt.req = 1'b1; nxt.rdy = 1'b1;
        step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 0, 0, "rw_run");
        idle(); nxt.br = 1'b1;
        step(1'b0, 5'b00000, 4'b1100, 1'b0, 1'b1, 0, 0, "rw_br");
        idle();
        step(1'b0, 5'b00000, 4'b1000, 1'b0, 1'b1, 0, 1, "rw_br_flush");

        // Non-forwarding instance, WB_HAZ=1.
        do_reset(1'b1);
        idle(); nxt.op = OP_R; nxt.rs1 = 5'd1; nxt.rs2 = 5'd3;
        nxt.wb_rd = 5'd3; nxt.wb_we = 1'b1;
        step(1'b1, 5'b11000, 4'b0100, 1'b0, 1'b1, 0, 0, "nf_wb");
        nxt.op = OP_I;
        step(1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 1, 0, "nf_rs2_unused");
        idle(); nxt.op = OP_I; nxt.rs1 = 5'd1; nxt.ex_rd = 5'd1; nxt.ex_we = 1'b1;
        step(1'b1, 5'b11000, 4'b0100, 1'b0, 1'b1, 1, 0, "nf_ex_alu");
        idle(); nxt.op = OP_R; nxt.rs2 = 5'd3; nxt.mem_rd = 5'd3; nxt.mem_we = 1'b1;
        step(1'b1, 5'b11000, 4'b0100, 1'b0, 1'b1, 2, 0, "nf_mem");
        idle(); nxt.op = OP_R; nxt.rs1 = 5'd3; nxt.wb_rd = 5'd3; nxt.wb_we = 1'b0;
        step(1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 3, 0, "nf_wb_off");
        idle(); nxt.op = OP_JAL; nxt.rs1 = 5'd4; nxt.ex_rd = 5'd4; nxt.ex_we = 1'b1;
        step(1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 3, 0, "nf_jal");
        idle();

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Parametrised pipeline hazard and flow controller for the 5-stage RISC-V core, driving the stall and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It covers:
- register RAW hazards, in forwarding or non-forwarding mode;
- taken-branch flush with a configurable multi-cycle penalty;
- data-memory wait-state freeze with a timeout flag;
- saturating stall and flush event counters.

It sits beside the stage registers and is the only source of their stall and flush enables.

## Interface
- REG_AW, 5: register-address width.
- FWD_EN, 1: 1 means a forwarding network exists, so only load-use stalls; 0 means any EX/MEM/WB producer stalls.
- WB_HAZ, 1: 1 means the register file is not write-through, so a WB producer also stalls (used only when FWD_EN=0).
- FLUSH_CYC, 1: cycles (1..7) for which IF/ID is flushed after a taken branch.
- MEM_TMO, 15: wait cycles after which mem_timeout_o sets.
- CNT_W, 16: event counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- ID_rs1_i, ID_rs2_i  in  REG_AW  source registers of the ID instruction.
- ID_opcode_i  in  7  ID opcode.
- EX_rd_i, MEM_rd_i, WB_rd_i  in  REG_AW  destination registers.
- EX_RegWr_en, MEM_RegWr_en, WB_RegWr_en  in  1  writeback enables.
- EX_MemRd_en  in  1  the EX instruction is a load.
- EX_Br_taken_i  in  1  branch/jump resolved taken in EX.
- MEM_Req_i  in  1  data-memory request from MEM.
- DMEM_ready_i  in  1  data memory ready.
- PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o, WB_stall_o  out  1  hold the register.
- IFID_flush_o, IDEX_flush_o, EXMEM_flush_o, WB_flush_o  out  1  load a bubble.
- mem_timeout_o  out  1  sticky timeout flag.
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters.

## Operation
**Operand use.**
- rs1 is used unless the opcode is JAL (1101111), LUI (0110111) or AUIPC (0010111).
- rs2 is used for opcodes 0110011, 1100011 and 0100011.
- A source equal to x0 never matches.

**RAW detection.**
- FWD_EN=1: raw = EX_MemRd_en & EX_RegWr_en & (used-source == EX_rd_i).
- FWD_EN=0: raw = a match against any enabled EX or MEM producer, or a WB producer if WB_HAZ=1.

**Priority, highest first.**
- MEM wait:
  - Condition: MEM_Req_i & !DMEM_ready_i.
  - Outputs: PC, IFID, IDEX and EXMEM stall; WB_flush; no other flush.
- Branch:
  - Condition: EX_Br_taken_i, or state FLUSH.
  - Outputs: IFID_flush on every such cycle; IDEX_flush only in the EX_Br_taken_i cycle; no stalls.
  - A RAW in the same cycle is discarded.
- RAW:
  - Outputs: PC and IFID stall; IDEX_flush.
- None: all outputs 0.

**FSM states** RUN, FLUSH and WAIT, held in a registered counter.
- RUN → FLUSH when EX_Br_taken_i, not in MEM wait, and FLUSH_CYC > 1. The FLUSH counter is loaded with FLUSH_CYC-1.
- FLUSH decrements each cycle that is not a MEM wait, and returns to RUN at 0.
  - A MEM wait during FLUSH freezes the counter.
  - A new EX_Br_taken_i during FLUSH reloads the counter.
- RUN or FLUSH → WAIT on a MEM wait condition, with the prior state saved. The wait counter clears on entry.
- WAIT increments the wait counter, saturating at MEM_TMO. It returns to the saved state the cycle after DMEM_ready_i is sampled high.
- mem_timeout_o sets when the wait counter reaches MEM_TMO and clears only on reset.

**Counters.**
- stall_cnt_o increments on every cycle with PC_stall_o = 1.
- flush_cnt_o increments once per EX_Br_taken_i cycle.
- Both saturate at all-ones and never wrap.

## Timing
- All stall and flush outputs are combinational from inputs plus registered state, and valid in the same cycle.
- The FSM, the counters and mem_timeout_o update on the rising edge of clk_i.
- **Reset (rst_n_i low, asynchronous):**
  - FSM = RUN; wait and flush counters = 0.
  - mem_timeout_o = 0; stall_cnt_o = flush_cnt_o = 0.
  - All stall outputs are forced to 0 and all flush outputs to 1 while reset is held, regardless of inputs.
  - Reset asserted mid-FLUSH or mid-WAIT abandons the state immediately.
- **Load-use with FWD_EN=1:** exactly one stall cycle. On the next cycle the load is in MEM and RAW deasserts.
- **Branch penalty:** FLUSH_CYC IF/ID bubbles plus 1 ID/EX bubble.

## Test plan
- **Load-use (FWD_EN=1):** EX holds lw x5 (MemRd, RegWr, rd=5); ID holds add x6,x5,x7.
  - Required: one cycle of PC_stall=IFID_stall=IDEX_flush=1; stall_cnt_o=1.
  - Repeated with rd=0: no stall.
- **Non-forwarding (FWD_EN=0, WB_HAZ=1):** ID rs2=3 with WB_rd=3, WB_RegWr=1.
  - Required: stall.
  - With ID opcode 0010011 (rs2 unused): no stall.
- **Branch (FLUSH_CYC=3):** EX_Br_taken_i pulse for 1 cycle.
  - Required: IDEX_flush for 1 cycle; IFID_flush for 3 consecutive cycles; flush_cnt_o=1.
  - A RAW asserted in the pulse cycle produces no stall.
- **MEM wait with timeout (MEM_TMO=4):** MEM_Req=1, DMEM_ready=0 for 6 cycles, then 1.
  - Required: PC..EXMEM stalled and WB_flush for all 6 cycles.
  - mem_timeout_o rises after cycle 4 and stays high after ready.
- **Wait during FLUSH (FLUSH_CYC=3):** branch taken, then a 2-cycle MEM wait in the next cycle.
  - Required: the wait has priority; after it, IFID_flush continues for the remaining 2 flush cycles.
- **Reset mid-WAIT:** assert rst_n_i low asynchronously in wait cycle 2.
  - Required: immediately, stalls=0, flushes=1, counters=0, mem_timeout_o=0.
  - After release, FSM is in RUN.
